cpu_dma_rx_reader: RTL and testbench

CPU_DMA_RX_READER -- requirements
Module: cpu_dma_rx_reader

---
 rtl/cpu_dma_pkg.sv | 42 ++++
 rtl/dma_out_reg.sv | 27 ++
 rtl/cpu_dma_rx_reader.sv | 116 +++++++++++
 tb/tb_cpu_dma_rx_reader.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_dma_pkg.sv
// Shared types for the CPU DMA rx reader: FSM encoding, length width and the
// last-word ctrl decode used by the byte counter.
package cpu_dma_pkg;

    localparam int unsigned LEN_WIDTH = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        XFER    = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0] bytes;
        logic       bad;
    } last_info_t;

    // One-hot ctrl gives the valid byte count of the last word; anything else is malformed.
    function automatic last_info_t last_word_info(input logic [3:0] ctrl);
        last_info_t info;
        info.bad = 1'b0;
        case (ctrl)
            4'b0001: info.bytes = 3'd1;
            4'b0010: info.bytes = 3'd2;
            4'b0100: info.bytes = 3'd3;
            4'b1000: info.bytes = 3'd4;
            default: begin
                info.bytes = 3'd4;
                info.bad   = 1'b1;
            end
        endcase
        return info;
    endfunction

    function automatic logic [LEN_WIDTH-1:0] sat_add(input logic [LEN_WIDTH-1:0] a,
                                                     input logic [2:0]           b);
        logic [LEN_WIDTH:0] sum;
        sum = {1'b0, a} + (LEN_WIDTH+1)'(b);
        return sum[LEN_WIDTH] ? {LEN_WIDTH{1'b1}} : sum[LEN_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/dma_out_reg.sv
// Single-entry output register: a load captures the word and raises valid,
// an accept without a load drops valid, otherwise everything holds.
module dma_out_reg #(
    parameter int unsigned WIDTH = 36
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             ready,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    always_ff @(posedge clk) begin
        if (reset) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/cpu_dma_rx_reader.sv
// Drains complete packets from the CPU rx queue into a valid/ready stream and
// reports per-packet byte length, error flag and a running packet count.
module cpu_dma_rx_reader
    import cpu_dma_pkg::*;
#(
    parameter int unsigned DMA_DATA_WIDTH = 32,
    parameter int unsigned DMA_CTRL_WIDTH = DMA_DATA_WIDTH / 8,
    parameter int unsigned MAX_PKT_BYTES  = 2048
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cpu_q_dma_pkt_avail,
    output logic                      cpu_q_dma_rd,
    input  logic [DMA_DATA_WIDTH-1:0] cpu_q_dma_rd_data,
    input  logic [DMA_CTRL_WIDTH-1:0] cpu_q_dma_rd_ctrl,
    input  logic                      rx_enable,
    output logic [DMA_DATA_WIDTH-1:0] dma_rx_data,
    output logic [DMA_CTRL_WIDTH-1:0] dma_rx_ctrl,
    output logic                      dma_rx_valid,
    input  logic                      dma_rx_ready,
    output logic                      pkt_done,
    output logic [LEN_WIDTH-1:0]      pkt_len_bytes,
    output logic                      pkt_err,
    output logic [31:0]               pkt_count
);

    localparam int unsigned OUT_WIDTH = DMA_DATA_WIDTH + DMA_CTRL_WIDTH;

    state_t               state;
    state_t               state_next;
    logic                 hold_cnt;
    logic [LEN_WIDTH-1:0] byte_cnt;
    logic [LEN_WIDTH-1:0] final_len;
    logic                 last_pop;
    logic                 ctrl_high_bad;
    last_info_t           info;
    logic [OUT_WIDTH-1:0] out_word;

    // Next state and pop strobe; pops only in XFER when the output slot frees up.
    always_comb begin
        state_next   = state;
        cpu_q_dma_rd = 1'b0;
        case (state)
            IDLE: begin
                if (rx_enable && cpu_q_dma_pkt_avail) begin
                    state_next = XFER;
                end
            end
            XFER: begin
                cpu_q_dma_rd = !dma_rx_valid || dma_rx_ready;
                if (cpu_q_dma_rd && (|cpu_q_dma_rd_ctrl)) begin
                    state_next = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (hold_cnt) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign last_pop      = cpu_q_dma_rd && (|cpu_q_dma_rd_ctrl);
    assign info          = last_word_info(4'(cpu_q_dma_rd_ctrl));
    assign ctrl_high_bad = |(cpu_q_dma_rd_ctrl >> 4);
    assign final_len     = sat_add(byte_cnt, info.bytes);

    // Byte accounting and completion report; the report is latched at the last pop,
    // independent of when the consumer takes the last word.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt      <= 1'b0;
            byte_cnt      <= '0;
            pkt_done      <= 1'b0;
            pkt_len_bytes <= '0;
            pkt_err       <= 1'b0;
            pkt_count     <= '0;
        end else begin
            hold_cnt <= (state == HOLDOFF) ? ~hold_cnt : 1'b0;
            pkt_done <= last_pop;
            if (last_pop) begin
                byte_cnt      <= '0;
                pkt_len_bytes <= final_len;
                pkt_err       <= info.bad || ctrl_high_bad || (32'(final_len) > MAX_PKT_BYTES);
                pkt_count     <= pkt_count + 32'd1;
            end else if (cpu_q_dma_rd) begin
                byte_cnt <= sat_add(byte_cnt, 3'd4);
            end
        end
    end

    dma_out_reg #(
        .WIDTH(OUT_WIDTH)
    ) u_out_reg (
        .clk      (clk),
        .reset    (reset),
        .load     (cpu_q_dma_rd),
        .ready    (dma_rx_ready),
        .load_data({cpu_q_dma_rd_ctrl, cpu_q_dma_rd_data}),
        .data     (out_word),
        .valid    (dma_rx_valid)
    );

    assign dma_rx_data = out_word[DMA_DATA_WIDTH-1:0];
    assign dma_rx_ctrl = out_word[OUT_WIDTH-1:DMA_DATA_WIDTH];

endmodule

// File: tb/tb_cpu_dma_rx_reader.sv
// Bench for cpu_dma_rx_reader: FWFT queue model, word and packet scoreboards,
// a packet table plus hand sequences for back-to-back, enable and reset cases.
module tb_cpu_dma_rx_reader;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_enable;
    logic          avail = 1'b0;
    logic          q_rd;
    logic [DW-1:0] q_data = '0;
    logic [CW-1:0] q_ctrl = '0;
    logic [DW-1:0] rx_data;
    logic [CW-1:0] rx_ctrl;
    logic          rx_valid;
    logic          rx_ready = 1'b1;
    logic          pkt_done;
    logic [11:0]   pkt_len;
    logic          pkt_err;
    logic [31:0]   pkt_count;

    always #5 clk = ~clk;

    cpu_dma_rx_reader #(
        .DMA_DATA_WIDTH(DW),
        .DMA_CTRL_WIDTH(CW),
        .MAX_PKT_BYTES (2048)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .cpu_q_dma_pkt_avail(avail),
        .cpu_q_dma_rd       (q_rd),
        .cpu_q_dma_rd_data  (q_data),
        .cpu_q_dma_rd_ctrl  (q_ctrl),
        .rx_enable          (rx_enable),
        .dma_rx_data        (rx_data),
        .dma_rx_ctrl        (rx_ctrl),
        .dma_rx_valid       (rx_valid),
        .dma_rx_ready       (rx_ready),
        .pkt_done           (pkt_done),
        .pkt_len_bytes      (pkt_len),
        .pkt_err            (pkt_err),
        .pkt_count          (pkt_count)
    );

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } word_t;

    typedef struct packed {
        logic [11:0] len;
        logic        err;
        logic [31:0] count;
    } pkt_exp_t;

    typedef struct {
        int         nwords;
        logic [3:0] last_ctrl;
        logic       toggle;
        int         exp_len;
        logic       exp_err;
    } vec_t;

    word_t    q[$];
    word_t    sb[$];
    pkt_exp_t pq[$];

    int tests = 0;
    int fails = 0;
    int ncyc = 0;
    int pops = 0;
    int beats = 0;
    int dones = 0;
    int last_pop_cyc = 0;
    int gap = 0;
    int rise_cyc = 0;
    int pkt_first = -1;
    int pkt_last = -1;
    logic after_last = 1'b1;
    logic lat_armed = 1'b0;
    logic stalled_prev = 1'b0;
    logic ready_mode = 1'b0;
    word_t held;
    int unsigned exp_count = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Queue model, ready pattern and all output monitoring, evaluated mid-cycle.
    always @(negedge clk) begin
        int    cur;
        int    n;
        logic  prev_avail;
        word_t w;
        pkt_exp_t e;
        cur = ncyc;
        ncyc++;
        rx_ready = ready_mode ? ~rx_ready : 1'b1;
        if (q.size() > 0) begin
            q_data = q[0].data;
            q_ctrl = q[0].ctrl;
        end else begin
            q_data = '0;
            q_ctrl = '0;
        end
        n = 0;
        foreach (q[i]) if (q[i].ctrl != '0) n++;
        prev_avail = avail;
        avail = (n > 0);
        if (avail && !prev_avail && rx_enable) begin
            rise_cyc  = cur;
            lat_armed = 1'b1;
        end
        #1;
        if (reset) begin
            q.delete();
            stalled_prev = 1'b0;
            lat_armed    = 1'b0;
        end else begin
            if (q_rd) begin
                if (q.size() == 0) begin
                    chk("pop_nonempty", 64'(q.size()), 64'd1);
                end else begin
                    if (after_last) begin
                        gap        = cur - last_pop_cyc;
                        after_last = 1'b0;
                    end
                    if (q[0].ctrl != '0) begin
                        last_pop_cyc = cur;
                        after_last   = 1'b1;
                    end
                    void'(q.pop_front());
                    pops++;
                end
            end
            if (stalled_prev) begin
                chk("hold_valid", 64'(rx_valid), 64'd1);
                chk("hold_word", 64'({rx_ctrl, rx_data}), 64'(held));
            end
            if (rx_valid && !rx_ready) chk("no_pop_stall", 64'(q_rd), 64'd0);
            stalled_prev = rx_valid && !rx_ready;
            held = {rx_ctrl, rx_data};
            if (lat_armed && rx_valid) begin
                chk("first_word_latency", 64'(cur - rise_cyc), 64'd2);
                lat_armed = 1'b0;
            end
            if (rx_valid && rx_ready) begin
                if (sb.size() == 0) begin
                    chk("beat_expected", 64'(sb.size()), 64'd1);
                end else begin
                    w = sb.pop_front();
                    chk("beat_word", 64'({rx_ctrl, rx_data}), 64'(w));
                end
                beats++;
                if (pkt_first < 0) pkt_first = cur;
                pkt_last = cur;
            end
            if (pkt_done) begin
                if (pq.size() == 0) begin
                    chk("done_expected", 64'(pq.size()), 64'd1);
                end else begin
                    e = pq.pop_front();
                    chk("pkt_len", 64'(pkt_len), 64'(e.len));
                    chk("pkt_err", 64'(pkt_err), 64'(e.err));
                    chk("pkt_count", 64'(pkt_count), 64'(e.count));
                end
                dones++;
            end
        end
    end

    task automatic send_words(input int n, input logic [3:0] last_ctrl);
        word_t w;
        for (int i = 0; i < n; i++) begin
            w.data = $urandom;
            w.ctrl = (i == n - 1) ? CW'(last_ctrl) : '0;
            q.push_back(w);
            sb.push_back(w);
        end
    endtask

    task automatic send_pkt(input int n, input logic [3:0] last_ctrl, input int len, input logic err);
        pkt_exp_t e;
        send_words(n, last_ctrl);
        exp_count++;
        e.len   = 12'(len);
        e.err   = err;
        e.count = exp_count;
        pq.push_back(e);
    endtask

    task automatic wait_idle(input int target, input int budget);
        int k;
        k = 0;
        while ((dones < target || sb.size() != 0) && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk("wait_done_in_budget", 64'(k < budget), 64'd1);
        repeat (4) @(posedge clk);
        #2;
    endtask

    task automatic wait_pops(input int target, input int budget);
        int k;
        k = 0;
        while (pops < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        #2;
        chk("pops_reached", 64'(pops >= target), 64'd1);
    endtask

    task automatic chk_reset_values();
        chk("rst_valid", 64'(rx_valid), 64'd0);
        chk("rst_data", 64'(rx_data), 64'd0);
        chk("rst_ctrl", 64'(rx_ctrl), 64'd0);
        chk("rst_done", 64'(pkt_done), 64'd0);
        chk("rst_len", 64'(pkt_len), 64'd0);
        chk("rst_err", 64'(pkt_err), 64'd0);
        chk("rst_count", 64'(pkt_count), 64'd0);
        chk("rst_rd", 64'(q_rd), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got %0d done packets", dones);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        int   b0;
        int   p0;
        int   d0;
        vecs[0] = '{16,   4'b1000, 1'b0, 64,   1'b0};
        vecs[1] = '{3,    4'b0001, 1'b0, 9,    1'b0};
        vecs[2] = '{3,    4'b0110, 1'b0, 12,   1'b1};
        vecs[3] = '{10,   4'b1000, 1'b1, 40,   1'b0};
        vecs[4] = '{520,  4'b1000, 1'b0, 2080, 1'b1};
        vecs[5] = '{1,    4'b0010, 1'b0, 2,    1'b0};
        vecs[6] = '{2,    4'b0100, 1'b0, 7,    1'b0};
        vecs[7] = '{1,    4'b1111, 1'b0, 4,    1'b1};
        vecs[8] = '{512,  4'b1000, 1'b0, 2048, 1'b0};
        vecs[9] = '{1100, 4'b1000, 1'b0, 4095, 1'b1};

        reset     = 1'b1;
        rx_enable = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        chk_reset_values();
        @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        for (int i = 0; i < 10; i++) begin
            ready_mode = vecs[i].toggle;
            b0 = beats;
            p0 = pops;
            pkt_first = -1;
            send_pkt(vecs[i].nwords, vecs[i].last_ctrl, vecs[i].exp_len, vecs[i].exp_err);
            wait_idle(dones + 1, 3000);
            ready_mode = 1'b0;
            chk("beats_per_pkt", 64'(beats - b0), 64'(vecs[i].nwords));
            chk("pops_per_pkt", 64'(pops - p0), 64'(vecs[i].nwords));
            if (!vecs[i].toggle) chk("contiguous_beats", 64'(pkt_last - pkt_first), 64'(vecs[i].nwords - 1));
            chk("count_after_pkt", 64'(pkt_count), 64'(exp_count));
        end

        // Two packets queued together: three pop-free cycles between them.
        send_pkt(4, 4'b1000, 16, 1'b0);
        send_pkt(3, 4'b0001, 9, 1'b0);
        wait_idle(dones + 2, 200);
        chk("b2b_idle_cycles", 64'(gap - 1), 64'd3);

        // Disabled before start: nothing is popped until re-enabled.
        rx_enable = 1'b0;
        p0 = pops;
        send_pkt(2, 4'b0100, 7, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        chk("enable_gate", 64'(pops - p0), 64'd0);
        rx_enable = 1'b1;
        wait_idle(dones + 1, 200);

        // Disabled mid-packet: the packet still completes.
        p0 = pops;
        send_pkt(8, 4'b1000, 32, 1'b0);
        wait_pops(p0 + 3, 100);
        rx_enable = 1'b0;
        wait_idle(dones + 1, 200);
        chk("mid_disable_pops", 64'(pops - p0), 64'd8);
        rx_enable = 1'b1;

        // Reset at word 5 of 12 abandons the packet.
        p0 = pops;
        d0 = dones;
        send_words(12, 4'b1000);
        wait_pops(p0 + 5, 100);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2;
        chk_reset_values();
        sb.delete();
        exp_count = 0;
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        chk("no_done_after_reset", 64'(dones - d0), 64'd0);
        send_pkt(3, 4'b1000, 12, 1'b0);
        wait_idle(dones + 1, 200);
        chk("count_restart", 64'(pkt_count), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
